// File: rtl/pe_sat_mac.sv
// Systolic PE: forwards operands with 1-cycle latency, saturating fixed-point MAC for K beats, then joins a column drain chain.
// Latency: operands and MAC result 1 cycle; no backpressure -- beats arriving in DONE are forwarded only.
module pe_sat_mac #(
    parameter int W     = 32,
    parameter int FRAC  = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [CNT_W-1:0] k_len,
    input  logic             in_valid,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    output logic             out_valid,
    output logic [W-1:0]     out_a,
    output logic [W-1:0]     out_b,
    input  logic             drain,
    input  logic [W-1:0]     c_in,
    output logic [W-1:0]     c_out,
    output logic             done,
    output logic             ovf
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

    state_t           state, state_nxt;
    logic [CNT_W-1:0] count, count_nxt, k_reg, k_nxt, k_eff, count_inc;
    logic [W-1:0]     c_nxt, c_base, prod_sat, sum_sat;
    logic             ovf_nxt, prod_fits, sum_fits, mac_sat;

    logic signed [2*W-1:0] a_ext, b_ext, prod_full, prod_shr;
    logic [W:0]            sum_ext;

    // Operand forwarding is independent of the MAC state and of clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_a <= in_a;
                out_b <= in_b;
            end
        end
    end

    assign a_ext     = {{W{in_a[W-1]}}, in_a};
    assign b_ext     = {{W{in_b[W-1]}}, in_b};
    assign prod_full = a_ext * b_ext;
    assign prod_shr  = prod_full >>> FRAC;

    // The shifted product fits when all bits from W-1 upward are copies of the sign.
    assign prod_fits = (prod_shr[2*W-1:W-1] == '0) || (prod_shr[2*W-1:W-1] == '1);
    assign prod_sat  = prod_fits ? prod_shr[W-1:0] : (prod_shr[2*W-1] ? SAT_MIN : SAT_MAX);

    assign c_base    = (state == IDLE) ? '0 : c_out;
    assign sum_ext   = {c_base[W-1], c_base} + {prod_sat[W-1], prod_sat};
    assign sum_fits  = (sum_ext[W] == sum_ext[W-1]);
    assign sum_sat   = sum_fits ? sum_ext[W-1:0] : (sum_ext[W] ? SAT_MIN : SAT_MAX);
    assign mac_sat   = !prod_fits || !sum_fits;

    assign k_eff     = (k_len == '0) ? CNT_W'(1) : k_len;
    assign count_inc = count + 1'b1;

    always_comb begin
        state_nxt = state;
        c_nxt     = c_out;
        count_nxt = count;
        k_nxt     = k_reg;
        ovf_nxt   = ovf;
        if (clear) begin
            state_nxt = IDLE;
            c_nxt     = '0;
            count_nxt = '0;
            k_nxt     = '0;
            ovf_nxt   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        k_nxt     = k_eff;
                        c_nxt     = sum_sat;
                        count_nxt = CNT_W'(1);
                        ovf_nxt   = ovf | mac_sat;
                        state_nxt = (k_eff == CNT_W'(1)) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        c_nxt     = sum_sat;
                        count_nxt = count_inc;
                        ovf_nxt   = ovf | mac_sat;
                        if (count_inc == k_reg) state_nxt = DONE;
                    end
                end
                DONE: begin
                    if (drain) c_nxt = c_in;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            c_out <= '0;
            count <= '0;
            k_reg <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            c_out <= c_nxt;
            count <= count_nxt;
            k_reg <= k_nxt;
            ovf   <= ovf_nxt;
        end
    end

    assign done = (state == DONE);

endmodule

// File: tb/tb_pe_sat_mac.sv
// Directed bench for pe_sat_mac: a 3-PE drain column, PE0 used for the MAC scenarios.
module tb_pe_sat_mac;
    localparam int W = 32;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             clear = 1'b0;
    logic             drain = 1'b0;
    logic [CNT_W-1:0] k_len     [3];
    logic             in_valid  [3];
    logic [W-1:0]     in_a      [3];
    logic [W-1:0]     in_b      [3];
    logic             out_valid [3];
    logic [W-1:0]     out_a     [3];
    logic [W-1:0]     out_b     [3];
    logic [W-1:0]     c_out     [3];
    logic             done      [3];
    logic             ovf       [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_col
        pe_sat_mac #(.W(W), .FRAC(16), .CNT_W(CNT_W)) u_pe (
            .clk      (clk),
            .rst      (rst),
            .clear    (clear),
            .k_len    (k_len[g]),
            .in_valid (in_valid[g]),
            .in_a     (in_a[g]),
            .in_b     (in_b[g]),
            .out_valid(out_valid[g]),
            .out_a    (out_a[g]),
            .out_b    (out_b[g]),
            .drain    (drain),
            .c_in     ((g == 0) ? 32'd0 : c_out[(g == 0) ? 0 : g - 1]),
            .c_out    (c_out[g]),
            .done     (done[g]),
            .ovf      (ovf[g])
        );
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int idx, input logic [CNT_W-1:0] k, input logic [W-1:0] a, input logic [W-1:0] b);
        k_len[idx]    = k;
        in_a[idx]     = a;
        in_b[idx]     = b;
        in_valid[idx] = 1'b1;
        tick();
        in_valid[idx] = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            k_len[i] = '0; in_valid[i] = 1'b0; in_a[i] = '0; in_b[i] = '0;
        end
        #3;
        check("rst_c_out", c_out[0], 32'h0);
        check("rst_done", {31'd0, done[0]}, 32'h0);
        check("rst_ovf", {31'd0, ovf[0]}, 32'h0);
        check("rst_out_valid", {31'd0, out_valid[0]}, 32'h0);
        check("rst_out_a", out_a[0], 32'h0);
        tick();
        rst = 1'b1;
        tick();

        // K=3, 1.5 * 2.0 back to back
        k_len[0] = 8'd3; in_a[0] = 32'h0001_8000; in_b[0] = 32'h0002_0000; in_valid[0] = 1'b1;
        tick();
        check("k3_beat1", c_out[0], 32'h0003_0000);
        check("k3_beat1_done", {31'd0, done[0]}, 32'h0);
        check("fwd_valid", {31'd0, out_valid[0]}, 32'h1);
        check("fwd_a", out_a[0], 32'h0001_8000);
        check("fwd_b", out_b[0], 32'h0002_0000);
        tick();
        check("k3_beat2", c_out[0], 32'h0006_0000);
        tick();
        check("k3_beat3", c_out[0], 32'h0009_0000);
        check("k3_done", {31'd0, done[0]}, 32'h1);
        check("k3_ovf", {31'd0, ovf[0]}, 32'h0);
        in_valid[0] = 1'b0; in_a[0] = 32'hDEAD_BEEF;
        tick();
        check("fwd_idle_valid", {31'd0, out_valid[0]}, 32'h0);
        check("fwd_idle_hold_a", out_a[0], 32'h0001_8000);
        beat(0, 8'd1, 32'h1234_5678, 32'h0000_0001);
        check("done_fwd_a", out_a[0], 32'h1234_5678);
        check("done_fwd_b", out_b[0], 32'h0000_0001);
        check("done_fwd_valid", {31'd0, out_valid[0]}, 32'h1);
        check("done_no_accum", c_out[0], 32'h0009_0000);
        do_clear();
        check("clear_c_out", c_out[0], 32'h0);
        check("clear_done", {31'd0, done[0]}, 32'h0);

        // Sign handling and floor truncation; k_len=0 acts as 1
        beat(0, 8'd1, 32'hFFFF_0000, 32'h0000_8000);
        check("neg_half", c_out[0], 32'hFFFF_8000);
        check("neg_half_done", {31'd0, done[0]}, 32'h1);
        do_clear();
        beat(0, 8'd0, 32'hFFFF_FFFF, 32'h0000_8000);
        check("floor", c_out[0], 32'hFFFF_FFFF);
        check("k0_done", {31'd0, done[0]}, 32'h1);
        do_clear();

        // Saturation and sticky ovf
        beat(0, 8'd2, 32'h7FFF_0000, 32'h0001_0000);
        check("sat_beat1", c_out[0], 32'h7FFF_0000);
        check("sat_beat1_ovf", {31'd0, ovf[0]}, 32'h0);
        beat(0, 8'd2, 32'h0001_0000, 32'h0001_0000);
        check("sat_sum", c_out[0], 32'h7FFF_FFFF);
        check("sat_ovf", {31'd0, ovf[0]}, 32'h1);
        for (int i = 0; i < 5; i++) tick();
        check("ovf_sticky", {31'd0, ovf[0]}, 32'h1);
        do_clear();
        check("ovf_cleared", {31'd0, ovf[0]}, 32'h0);

        // Product saturation on its own, negative side
        beat(0, 8'd1, 32'h8000_0000, 32'h0100_0000);
        check("prod_sat_neg", c_out[0], 32'h8000_0000);
        check("prod_sat_ovf", {31'd0, ovf[0]}, 32'h1);
        do_clear();

        // K=4 with 2-cycle gaps; k_len changed after capture must be ignored
        beat(0, 8'd4, 32'h0001_0000, 32'h0002_0000);
        k_len[0] = 8'd1;
        for (int n = 1; n < 4; n++) begin
            tick(); tick();
            check("gap_hold", c_out[0], 32'(n) * 32'h0002_0000);
            in_a[0] = 32'h0001_0000; in_b[0] = 32'h0002_0000; in_valid[0] = 1'b1;
            tick();
            in_valid[0] = 1'b0;
            if (n == 2) check("gap_not_done", {31'd0, done[0]}, 32'h0);
        end
        check("gap_final", c_out[0], 32'h0008_0000);
        check("gap_done", {31'd0, done[0]}, 32'h1);
        do_clear();

        // clear wins over a beat mid-ACCUM; beat still forwarded
        beat(0, 8'd3, 32'h0001_0000, 32'h0001_0000);
        check("midacc_beat1", c_out[0], 32'h0001_0000);
        clear = 1'b1; in_valid[0] = 1'b1; in_a[0] = 32'h0003_0000; in_b[0] = 32'h0004_0000;
        tick();
        clear = 1'b0; in_valid[0] = 1'b0;
        check("clr_beat_c_out", c_out[0], 32'h0);
        check("clr_beat_fwd_a", out_a[0], 32'h0003_0000);
        check("clr_beat_fwd_valid", {31'd0, out_valid[0]}, 32'h1);
        beat(0, 8'd1, 32'h0001_0000, 32'h0005_0000);
        check("after_clr_idle", c_out[0], 32'h0005_0000);
        check("after_clr_done", {31'd0, done[0]}, 32'h1);
        do_clear();

        // Drain a 3-PE column
        for (int i = 0; i < 3; i++) begin
            k_len[i] = 8'd1; in_a[i] = 32'(i + 1) * 32'h11; in_b[i] = 32'h0001_0000; in_valid[i] = 1'b1;
        end
        tick();
        for (int i = 0; i < 3; i++) in_valid[i] = 1'b0;
        check("col_top", c_out[0], 32'h11);
        check("col_mid", c_out[1], 32'h22);
        drain = 1'b1;
        check("drain_c0", c_out[2], 32'h33);
        tick();
        check("drain_c1", c_out[2], 32'h22);
        tick();
        check("drain_c2", c_out[2], 32'h11);
        tick();
        drain = 1'b0;
        for (int i = 0; i < 3; i++) check("drain_empty", c_out[i], 32'h0);
        check("drain_stays_done", {31'd0, done[2]}, 32'h1);

        // Asynchronous reset mid-drain
        do_clear();
        for (int i = 0; i < 3; i++) begin
            k_len[i] = 8'd1; in_a[i] = 32'(i + 1) * 32'h11; in_b[i] = 32'h0001_0000; in_valid[i] = 1'b1;
        end
        tick();
        for (int i = 0; i < 3; i++) in_valid[i] = 1'b0;
        drain = 1'b1;
        tick();
        check("pre_rst_drain", c_out[2], 32'h22);
        rst = 1'b0;
        #2;
        for (int i = 0; i < 3; i++) check("arst_c_out", c_out[i], 32'h0);
        check("arst_done", {31'd0, done[2]}, 32'h0);
        check("arst_out_a", out_a[0], 32'h0);
        drain = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        beat(0, 8'd1, 32'h0001_0000, 32'h0001_0000);
        check("post_rst_k1", c_out[0], 32'h0001_0000);
        check("post_rst_done", {31'd0, done[0]}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
